// File: rtl/pmem_pkg.sv
// Shared types and defaults for the line-to-burst memory adaptor.
package pmem_pkg;

  localparam int LINE_BITS = 256;
  localparam int BEAT_BITS = 64;
  localparam int ADDR_BITS = 32;
  localparam int BEATS     = LINE_BITS / BEAT_BITS;

  typedef enum logic [1:0] {
    IDLE,
    RD_BURST,
    WR_BURST,
    DONE
  } burst_state_t;

  function automatic logic [63:0] line_align(
    input logic [63:0] a,
    input int          off_bits
  );
    logic [63:0] m;
    m = {64{1'b1}} << off_bits;
    return a & m;
  endfunction

endpackage

// File: rtl/pmem_line_buffer.sv
// Cacheline register with a beat-indexed write port, full-line load
// and beat-indexed read mux.
module pmem_line_buffer #(
  parameter int LINE_BITS = pmem_pkg::LINE_BITS,
  parameter int BEAT_BITS = pmem_pkg::BEAT_BITS,
  parameter int IW        = $clog2(LINE_BITS / BEAT_BITS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [IW-1:0]        idx,
  input  logic [BEAT_BITS-1:0] beat_in,
  input  logic                 load,
  input  logic [LINE_BITS-1:0] line_in,
  output logic [LINE_BITS-1:0] line_out,
  output logic [BEAT_BITS-1:0] beat_out
);

  logic [LINE_BITS-1:0] buf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q <= '0;
    end else if (load) begin
      buf_q <= line_in;
    end else if (we) begin
      buf_q[int'(idx)*BEAT_BITS +: BEAT_BITS] <= beat_in;
    end
  end

  assign line_out = buf_q;
  assign beat_out = buf_q[int'(idx)*BEAT_BITS +: BEAT_BITS];

endmodule

// File: rtl/pmem_burst_adaptor.sv
// Turns single-response cacheline requests into ascending beat bursts
// and keeps a sticky flag for upstream protocol violations.
module pmem_burst_adaptor #(
  parameter int LINE_BITS = pmem_pkg::LINE_BITS,
  parameter int BEAT_BITS = pmem_pkg::BEAT_BITS,
  parameter int ADDR_BITS = pmem_pkg::ADDR_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 line_read,
  input  logic                 line_write,
  input  logic [ADDR_BITS-1:0] line_address,
  input  logic [LINE_BITS-1:0] line_wdata,
  output logic [LINE_BITS-1:0] line_rdata,
  output logic                 line_resp,
  output logic                 burst_read,
  output logic                 burst_write,
  output logic [ADDR_BITS-1:0] burst_address,
  output logic [BEAT_BITS-1:0] burst_wdata,
  input  logic [BEAT_BITS-1:0] burst_rdata,
  input  logic                 burst_resp,
  output logic                 proto_err
);

  import pmem_pkg::*;

  localparam int NBEATS   = LINE_BITS / BEAT_BITS;
  localparam int IW       = $clog2(NBEATS);
  localparam int OFF_BITS = $clog2(LINE_BITS / 8);
  localparam logic [IW-1:0] LAST = IW'(NBEATS - 1);

  burst_state_t         state_q, state_d;
  logic [IW-1:0]        k_q, k_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic                 err_q, err_d;
  logic                 rd_q, wr_q, resp_q;
  logic [ADDR_BITS-1:0] al;
  logic                 rbuf_we, wbuf_load;
  logic [BEAT_BITS-1:0] unused_rbeat;
  logic [LINE_BITS-1:0] unused_wline;

  assign al = ADDR_BITS'(line_align(64'(line_address), OFF_BITS));

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    addr_d    = addr_q;
    err_d     = err_q;
    rbuf_we   = 1'b0;
    wbuf_load = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (line_read) begin
          addr_d  = al;
          k_d     = '0;
          state_d = RD_BURST;
          if (line_write) err_d = 1'b1;
        end else if (line_write) begin
          addr_d    = al;
          k_d       = '0;
          wbuf_load = 1'b1;
          state_d   = WR_BURST;
        end
      end
      RD_BURST: begin
        if (!line_read || line_write || al != addr_q) err_d = 1'b1;
        if (burst_resp) begin
          rbuf_we = 1'b1;
          k_d     = k_q + IW'(1);
          if (k_q == LAST) state_d = DONE;
        end
      end
      WR_BURST: begin
        if (line_read || !line_write || al != addr_q) err_d = 1'b1;
        if (burst_resp) begin
          k_d = k_q + IW'(1);
          if (k_q == LAST) state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they come straight off flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      addr_q  <= '0;
      err_q   <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      resp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
      rd_q    <= (state_d == RD_BURST);
      wr_q    <= (state_d == WR_BURST);
      resp_q  <= (state_d == DONE);
    end
  end

  pmem_line_buffer #(
    .LINE_BITS(LINE_BITS),
    .BEAT_BITS(BEAT_BITS),
    .IW       (IW)
  ) u_rbuf (
    .clk     (clk),
    .rst     (rst),
    .we      (rbuf_we),
    .idx     (k_q),
    .beat_in (burst_rdata),
    .load    (1'b0),
    .line_in ('0),
    .line_out(line_rdata),
    .beat_out(unused_rbeat)
  );

  pmem_line_buffer #(
    .LINE_BITS(LINE_BITS),
    .BEAT_BITS(BEAT_BITS),
    .IW       (IW)
  ) u_wbuf (
    .clk     (clk),
    .rst     (rst),
    .we      (1'b0),
    .idx     (k_q),
    .beat_in ('0),
    .load    (wbuf_load),
    .line_in (line_wdata),
    .line_out(unused_wline),
    .beat_out(burst_wdata)
  );

  assign burst_read    = rd_q;
  assign burst_write   = wr_q;
  assign burst_address = addr_q;
  assign line_resp     = resp_q;
  assign proto_err     = err_q;

endmodule

// File: tb/tb_pmem_burst_adaptor.sv
// Self-checking bench: table of line transactions against a beat-level
// memory model, plus a mid-burst reset sequence.
module tb_pmem_burst_adaptor;

  logic         clk = 1'b0;
  logic         rst;
  logic         line_read, line_write;
  logic [31:0]  line_address;
  logic [255:0] line_wdata, line_rdata;
  logic         line_resp;
  logic         burst_read, burst_write;
  logic [31:0]  burst_address;
  logic [63:0]  burst_wdata, burst_rdata;
  logic         burst_resp;
  logic         proto_err;

  always #5 clk = ~clk;

  pmem_burst_adaptor dut (
    .clk          (clk),
    .rst          (rst),
    .line_read    (line_read),
    .line_write   (line_write),
    .line_address (line_address),
    .line_wdata   (line_wdata),
    .line_rdata   (line_rdata),
    .line_resp    (line_resp),
    .burst_read   (burst_read),
    .burst_write  (burst_write),
    .burst_address(burst_address),
    .burst_wdata  (burst_wdata),
    .burst_rdata  (burst_rdata),
    .burst_resp   (burst_resp),
    .proto_err    (proto_err)
  );

  typedef struct {
    logic         wr, both, hold, b2b, poke;
    logic [31:0]  addr, paddr;
    logic [255:0] line;
    int           gap_beat, gap_len, exp_cyc;
    logic         exp_err;
  } vec_t;

  typedef struct {
    logic         wr;
    logic [255:0] line;
  } sb_t;

  sb_t  sbq[$];
  vec_t vecs[7];
  int   checks = 0;
  int   passes = 0;

  function automatic logic [255:0] mk(input logic [7:0] b0, b1, b2, b3);
    return {{8{b3}}, {8{b2}}, {8{b1}}, {8{b0}}};
  endfunction

  function automatic vec_t mkv(
    input logic wr, both, hold, b2b, poke,
    input logic [31:0] addr, paddr,
    input logic [255:0] line,
    input int gb, gl, cyc,
    input logic err
  );
    vec_t v;
    v.wr = wr; v.both = both; v.hold = hold; v.b2b = b2b; v.poke = poke;
    v.addr = addr; v.paddr = paddr; v.line = line;
    v.gap_beat = gb; v.gap_len = gl; v.exp_cyc = cyc; v.exp_err = err;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [255:0] act,
                     input logic [255:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic run_txn(input vec_t v);
    int   kb = 0;
    int   gap = 0;
    int   cyc = 0;
    bit   done = 0;
    sb_t  e;
    logic [31:0] al;
    al = v.addr & ~32'h1f;
    if (!v.b2b) @(negedge clk);
    line_read    = !v.wr;
    line_write   = v.wr | v.both;
    line_address = v.addr;
    line_wdata   = v.wr ? v.line : '0;
    e.wr = v.wr; e.line = v.line;
    sbq.push_back(e);
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      burst_resp = 1'b0;
      chk("rw_exclusive", {burst_read & burst_write}, 0);
      if (line_resp) begin
        chk("resp_cycle", cyc, v.exp_cyc);
        chk("proto_err", proto_err, v.exp_err);
        chk("beats_done", kb, 4);
        if (sbq.size() == 0) begin
          chk("unexpected_resp", 1, 0);
        end else begin
          e = sbq.pop_front();
          if (!e.wr) chk("line_rdata", line_rdata, e.line);
        end
        done = 1;
        if (!v.hold) begin
          line_read  = 1'b0;
          line_write = 1'b0;
        end
      end else if (burst_read || burst_write) begin
        chk("burst_address", burst_address, al);
        chk("burst_kind_wr", burst_write, v.wr);
        if (burst_write && kb < 4)
          chk("burst_wdata", burst_wdata, v.line[kb*64 +: 64]);
        if (kb == v.gap_beat && gap < v.gap_len) begin
          gap++;
        end else if (kb < 4) begin
          burst_resp  = 1'b1;
          burst_rdata = v.line[kb*64 +: 64];
          kb++;
          if (v.poke && kb == 2) line_address = v.paddr;
        end
      end
    end
    burst_resp = 1'b0;
    if (!done) begin
      checks++;
      $display("FAIL timeout: no line_resp within 40 cycles, wanted at %0d",
               v.exp_cyc);
    end
  endtask

  initial begin
    vecs[0] = mkv(0, 0, 0, 0, 0, 32'h64,   0, mk(8'h11, 8'h22, 8'h33, 8'h44), 9, 0, 5, 0);
    vecs[1] = mkv(1, 0, 0, 0, 0, 32'h1000, 0, mk(8'hA0, 8'hA1, 8'hA2, 8'hA3), 2, 2, 7, 0);
    vecs[2] = mkv(0, 1, 0, 0, 0, 32'h80,   0, mk(8'h01, 8'h02, 8'h03, 8'h04), 9, 0, 5, 1);
    vecs[3] = mkv(0, 0, 0, 0, 1, 32'h1000, 32'h2000, mk(8'h55, 8'h66, 8'h77, 8'h88), 9, 0, 5, 1);
    vecs[4] = mkv(0, 0, 0, 0, 0, 32'h4f,   0, mk(8'h9A, 8'hBC, 8'hDE, 8'hF0), 9, 0, 5, 0);
    vecs[5] = mkv(0, 0, 1, 0, 0, 32'h100,  0, mk(8'hC1, 8'hC2, 8'hC3, 8'hC4), 9, 0, 5, 0);
    vecs[6] = mkv(0, 0, 0, 1, 0, 32'h100,  0, mk(8'hD1, 8'hD2, 8'hD3, 8'hD4), 9, 0, 6, 0);

    rst = 1'b1;
    line_read = 0; line_write = 0; line_address = 0; line_wdata = 0;
    burst_rdata = 0; burst_resp = 0;
    repeat (3) @(negedge clk);
    chk("rst_line_resp", line_resp, 0);
    chk("rst_burst_read", burst_read, 0);
    chk("rst_burst_write", burst_write, 0);
    chk("rst_burst_address", burst_address, 0);
    chk("rst_burst_wdata", burst_wdata, 0);
    chk("rst_line_rdata", line_rdata, 0);
    chk("rst_proto_err", proto_err, 0);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) run_txn(vecs[i]);

    // Abandon a read after its third beat.
    @(negedge clk);
    line_address = 32'h300;
    line_read    = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      burst_resp  = 1'b1;
      burst_rdata = {8{8'hEE}};
    end
    @(negedge clk);
    burst_resp = 1'b0;
    chk("pre_rst_burst_read", burst_read, 1);
    rst       = 1'b1;
    line_read = 1'b0;
    @(negedge clk);
    chk("mid_rst_burst_read", burst_read, 0);
    chk("mid_rst_line_resp", line_resp, 0);
    chk("mid_rst_proto_err", proto_err, 0);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("post_rst_quiet", {line_resp, burst_read, burst_write}, 0);
    end

    for (int i = 4; i < 7; i++) run_txn(vecs[i]);

    chk("scoreboard_empty", sbq.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/pmem_burst_adaptor.md
# pmem_burst_adaptor

Converts the CPU-side physical-memory line interface (one 256-bit cacheline per request, single `resp`) into a 4-beat × 64-bit burst transaction toward the burst-capable main memory model. Sits directly downstream of `riscy_top`'s `pmem_*` port and upstream of the burst memory. It also flags upstream protocol violations: simultaneous read/write, and a request changing mid-transaction.

## Interface
- `LINE_BITS`, 256, cacheline width; must be a multiple of `BEAT_BITS`.
- `BEAT_BITS`, 64, burst beat width.
- `ADDR_BITS`, 32, byte address width.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `line_read`  in  1  upstream line read request.
- `line_write`  in  1  upstream line write request.
- `line_address`  in  ADDR_BITS  upstream byte address; low log2(LINE_BITS/8) bits ignored.
- `line_wdata`  in  LINE_BITS  write line.
- `line_rdata`  out  LINE_BITS  assembled read line.
- `line_resp`  out  1  one-cycle completion pulse.
- `burst_read`  out  1  downstream read request.
- `burst_write`  out  1  downstream write request.
- `burst_address`  out  ADDR_BITS  line-aligned address.
- `burst_wdata`  out  BEAT_BITS  current write beat.
- `burst_rdata`  in  BEAT_BITS  current read beat.
- `burst_resp`  in  1  beat accepted or returned this cycle.
- `proto_err`  out  1  sticky protocol-violation flag.

## Operation
- BEATS = LINE_BITS/BEAT_BITS = 4; beat counter `k` is log2(BEATS) bits; beats ascend, beat k ↔ bits [k*BEAT_BITS +: BEAT_BITS].
- FSM states: IDLE, RD_BURST, WR_BURST, DONE.
- IDLE: `line_read` → latch aligned address, k=0, go RD_BURST. `line_write` → also latch `line_wdata` into the write buffer, go WR_BURST. Both high → `proto_err` set, read wins.
- RD_BURST: `burst_read`=1. Each cycle with `burst_resp`: store `burst_rdata` into line buffer at k, k++. On the beat where k==BEATS-1 → DONE.
- WR_BURST: `burst_write`=1, `burst_wdata`=wbuf beat k. Each `burst_resp` → k++. Last beat → DONE.
- DONE: `line_resp`=1 for exactly one cycle, then IDLE.
- Gaps (resp low) between beats are legal; k holds.
- `line_rdata` is driven from the line buffer. It is valid in the DONE cycle and holds until the next read's first beat.
- Requests are sampled only in IDLE. A request still high in the cycle after DONE is a new transaction.
- While busy, if the upstream request kind or line address differs from the latched value, set `proto_err`. The transaction continues on the latched values.
- `burst_resp` in IDLE or DONE is ignored.
- `rst` mid-burst: state returns to IDLE and outputs deassert the next cycle. The burst is abandoned and no `line_resp` is issued. `proto_err` clears only on `rst`.

## Timing
- Reset values: `line_resp`=0, `burst_read`=0, `burst_write`=0, `burst_address`=0, `burst_wdata`=0, `line_rdata`=0, `proto_err`=0, state IDLE, k=0.
- `burst_read`/`burst_write` are registered: they assert the cycle after the request is seen in IDLE, and deassert in the cycle after the last `burst_resp`.
- `burst_read` and `burst_write` are never high together.
- Zero-wait memory: request seen at cycle 0, beats at cycles 1–4, `line_resp` at cycle 5. Back-to-back minimum spacing is 6 cycles.
- `burst_address` is stable for the whole burst.
- `burst_wdata` changes only in the cycle after a `burst_resp`.

## Structure
- Package `pmem_pkg`:
  - `LINE_BITS`, `BEAT_BITS`, `BEATS` defaults.
  - `burst_state_t` enum {IDLE, RD_BURST, WR_BURST, DONE}.
  - `line_align()` function that zeros the low offset bits.
- Sub-module `pmem_line_buffer`: LINE_BITS register with a beat-indexed write port (`we`, `idx`, `beat_in`), a full-line load port, and a beat-indexed read mux. One instance for read assembly, one for write disassembly.
- Top level holds only the FSM, beat counter, address latch and error logic.

## Test plan
- Read at 0x0000_0064, memory returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 with zero wait:
  - `burst_address`=0x0000_0060.
  - `line_resp` at cycle 5.
  - `line_rdata`={0x44..44, 0x33..33, 0x22..22, 0x11..11}.
- Write at 0x0000_1000 with line = beats 0xA0..A3 (low→high), memory inserts 2 idle cycles before beat 2:
  - `burst_wdata` sequence A0, A1, A2 (held 3 cycles), A3.
  - `line_resp` at cycle 7.
- `line_read` and `line_write` asserted together in IDLE → read burst runs, `proto_err`=1 and remains 1 after completion.
- `line_address` changed to 0x2000 after beat 1 of a read at 0x1000 → `burst_address` stays 0x1000, `proto_err`=1, line completes normally.
- `rst` asserted after beat 2 of a read:
  - Next cycle `burst_read`=0, state IDLE, no `line_resp`.
  - A new read afterwards completes with correct data.
- Two back-to-back reads with `line_read` held high across DONE → two bursts, two `line_resp` pulses 6 cycles apart.
